// File: rtl/s4ga_pkg.sv
// s4ga shared stream geometry and sequencer state encoding.
// Imported by the fabric and the configuration sequencer.
package s4ga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RESET,
    ST_RUN
  } cfg_state_e;

  function automatic int cdiv(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int idx_w(input int n, input int i);
    return $clog2(3 + i + n);
  endfunction

  function automatic int idx_segs(input int n, input int i,
                                  input int siw);
    return cdiv(idx_w(n, i), siw);
  endfunction

  function automatic int mask_segs(input int k, input int siw);
    return cdiv(1 << k, siw);
  endfunction

  function automatic int ll(input int n, input int k, input int i,
                            input int siw);
    return k * idx_segs(n, i, siw) + mask_segs(k, siw);
  endfunction

  function automatic int depth(input int n, input int k, input int i,
                               input int siw);
    return n * ll(n, k, i, siw);
  endfunction

endpackage

// File: rtl/s4ga_cfg_ram.sv
// Frame store: single port, synchronous read, one-cycle latency.
// Read data returns to zero when no read is issued.
module s4ga_cfg_ram #(
  parameter int DEPTH = 56,
  parameter int W     = 4,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // registered read, cleared when idle
  always_ff @(posedge clk) begin
    rdata <= re ? mem[addr] : '0;
  end

endmodule

// File: rtl/s4ga_cfg_seq.sv
// s4ga configuration sequencer: captures a frame, then holds
// the fabric in reset and replays the frame on si forever.
module s4ga_cfg_seq
  import s4ga_pkg::*;
#(
  parameter int N       = 89,
  parameter int K       = 5,
  parameter int I       = 2,
  parameter int SI_W    = 4,
  parameter int RST_CYC = N + 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [SI_W-1:0] ld_data,
  input  logic            ld_last,
  input  logic            run,
  output logic            fab_rst,
  output logic [SI_W-1:0] si,
  output logic            frame_done,
  output logic            loaded,
  output logic            len_err,
  output logic [15:0]     frames
);

  localparam int DEPTH = depth(N, K, I, SI_W);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(RST_CYC + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYC - 1);

  cfg_state_e    state, nxt;
  logic [AW-1:0] addr, rd_addr;
  logic [AW-1:0] wr_addr, rd_nxt, ram_addr;
  logic [CW-1:0] rst_cnt;
  logic          beat, beat_end, beat_ok, re, fd_nxt;

  assign ld_ready = rst &&
    (state == ST_IDLE || state == ST_LOAD);
  assign beat     = ld_valid && ld_ready;
  assign wr_addr  = (state == ST_LOAD) ? addr : '0;
  assign beat_end = ld_last || (wr_addr == LAST);
  assign beat_ok  = ld_last && (wr_addr == LAST);
  assign rd_nxt   = (rd_addr == LAST) ? '0 : rd_addr + 1'b1;
  assign re       = (nxt == ST_RUN);
  assign fd_nxt   = re && (ram_addr == LAST);

  // next state, RAM address select
  always_comb begin
    nxt      = state;
    ram_addr = wr_addr;
    unique case (state)
      ST_IDLE: begin
        if (beat)
          nxt = beat_end ? ST_IDLE : ST_LOAD;
        else if (run && loaded)
          nxt = ST_RESET;
      end
      ST_LOAD: begin
        if (beat && beat_end) nxt = ST_IDLE;
      end
      ST_RESET: begin
        ram_addr = '0;
        if (rst_cnt == RST_LAST) nxt = ST_RUN;
      end
      ST_RUN: begin
        ram_addr = rd_nxt;
        if (rd_addr == LAST && !run) nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
    if (!rst) nxt = ST_IDLE;
  end

  // state and stream-side registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      rd_addr    <= '0;
      rst_cnt    <= '0;
      fab_rst    <= 1'b1;
      frame_done <= 1'b0;
      frames     <= '0;
    end else begin
      state      <= nxt;
      fab_rst    <= (nxt != ST_RUN);
      frame_done <= fd_nxt;
      if (fd_nxt) frames <= frames + 16'd1;
      if (re) rd_addr <= ram_addr;
      if (state == ST_RESET) rst_cnt <= rst_cnt + 1'b1;
      else                   rst_cnt <= '0;
    end
  end

  // load address and frame status flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr    <= '0;
      loaded  <= 1'b0;
      len_err <= 1'b0;
    end else if (beat) begin
      addr <= beat_end ? '0 : wr_addr + 1'b1;
      if (state == ST_IDLE) begin
        loaded  <= 1'b0;
        len_err <= 1'b0;
      end
      if (beat_end) begin
        loaded  <= beat_ok;
        len_err <= !beat_ok;
      end
    end
  end

  s4ga_cfg_ram #(
    .DEPTH (DEPTH),
    .W     (SI_W),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (beat),
    .re    (re),
    .addr  (ram_addr),
    .wdata (ld_data),
    .rdata (si)
  );

endmodule

// File: tb/tb_s4ga_cfg_seq.sv
// Bench for s4ga_cfg_seq: directed loads/runs, expected stream
// queued by stimulus and consumed by an independent monitor.
module tb_s4ga_cfg_seq;

  localparam int N = 7, K = 4, I = 2, SI_W = 4;
  localparam int RST_CYC = 9;
  localparam int DEPTH = 56;

  typedef struct packed {
    logic [3:0] si;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_last = 1'b0;
  logic        run = 1'b0;
  logic [3:0]  ld_data = '0;
  logic        ld_ready, fab_rst, frame_done, loaded, len_err;
  logic [3:0]  si;
  logic [15:0] frames;

  exp_t       exp_q[$];
  logic [3:0] mdl [DEPTH];
  int         checks = 0;
  int         errors = 0;
  int         popped = 0;
  int         rdy_bad = 0;

  s4ga_cfg_seq #(
    .N(N), .K(K), .I(I), .SI_W(SI_W), .RST_CYC(RST_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last),
    .run(run), .fab_rst(fab_rst), .si(si),
    .frame_done(frame_done), .loaded(loaded),
    .len_err(len_err), .frames(frames)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int nb, input bit last_end,
                         input bit rnd, input bit stall);
    for (int b = 0; b < nb; b++) begin
      if (stall && b > 0) begin
        repeat ($urandom_range(0, 2)) begin
          ld_valid = 1'b0;
          #1;
          if (!ld_ready) rdy_bad++;
          tick();
        end
      end
      ld_valid = 1'b1;
      ld_data  = rnd ? 4'($urandom) : 4'(b % 16);
      ld_last  = last_end && (b == nb - 1);
      if (b < DEPTH) mdl[b] = ld_data;
      #1;
      if (!ld_ready) rdy_bad++;
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic push_frame();
    for (int s = 0; s < DEPTH; s++)
      exp_q.push_back('{si: mdl[s], fd: (s == DEPTH - 1)});
  endtask

  task automatic wait_pop(input int tgt, input string nm);
    int n = 0;
    while (popped < tgt && n < 500) begin
      tick();
      n++;
    end
    if (popped < tgt) chk(nm, popped, tgt);
  endtask

  // monitor: every live si beat must match the queued frame
  always @(negedge clk) begin
    if (rst && !fab_rst) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL si_extra: got si %0h with no beat expected",
                 si);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("si", {28'd0, si}, {28'd0, e.si});
        chk("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
        popped++;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int hi;
    int base;
    int bad;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_fab_rst", fab_rst, 1);
    chk("rst_si", si, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_frames", frames, 0);
    chk("rst_frame_done", frame_done, 0);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("idle_ld_ready", ld_ready, 1);

    // full frame, value = addr mod 16
    tick();
    do_load(DEPTH, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_loaded", loaded, 1);
    chk("full_len_err", len_err, 0);
    chk("full_ready_all", rdy_bad, 0);

    // stream three frames, drop run mid third frame
    tick();
    push_frame();
    push_frame();
    push_frame();
    run = 1'b1;
    hi = 0;
    repeat (30) begin
      @(negedge clk);
      if (!fab_rst) break;
      hi++;
    end
    chk("rst_hold_cycles", hi, 1 + RST_CYC);
    wait_pop(DEPTH + 1, "wait_frame1");
    chk("frames_after_1", frames, 1);
    wait_pop(2 * DEPTH + 21, "wait_seg20");
    run = 1'b0;
    wait_pop(3 * DEPTH, "wait_drain");
    tick();
    @(negedge clk);
    chk("drop_fab_rst", fab_rst, 1);
    chk("drop_si", si, 0);
    chk("drop_frames", frames, 3);
    chk("drop_idle_ready", ld_ready, 1);
    chk("drop_q_empty", exp_q.size(), 0);

    // random data with stalls; run raised with first beat
    tick();
    rdy_bad = 0;
    run = 1'b1;
    do_load(DEPTH, 1'b1, 1'b1, 1'b1);
    base = popped;
    push_frame();
    @(negedge clk);
    chk("rnd_loaded", loaded, 1);
    chk("rnd_ready_all", rdy_bad, 0);
    tick();
    wait_pop(base + 40, "wait_seg40");
    chk("pre_rst_frames", frames, 3);
    rst = 1'b0;
    run = 1'b0;
    @(negedge clk);
    chk("rstlow_ld_ready", ld_ready, 0);
    @(negedge clk);
    exp_q.delete();
    chk("midrun_fab_rst", fab_rst, 1);
    chk("midrun_si", si, 0);
    chk("midrun_loaded", loaded, 0);
    chk("midrun_frames", frames, 0);
    chk("midrun_frame_done", frame_done, 0);
    chk("midrun_ld_ready", ld_ready, 0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("release_ld_ready", ld_ready, 1);

    // short frame: ld_last on beat 30
    tick();
    do_load(30, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("short_len_err", len_err, 1);
    chk("short_loaded", loaded, 0);
    tick();
    run = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!fab_rst || !ld_ready) bad++;
    end
    chk("short_run_stays_idle", bad, 0);
    tick();
    run = 1'b0;

    // full length without ld_last
    do_load(DEPTH, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("nolast_len_err", len_err, 1);
    chk("nolast_loaded", loaded, 0);
    chk("nolast_ready", ld_ready, 1);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
